// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a build-time choice between registered and first-word-fall-through reads.
module sync_fifo_flags #(
    parameter int DT_WIDTH   = 8,
    parameter int F_DEPTH    = 16,
    parameter int FADD_WIDTH = $clog2(F_DEPTH),
    parameter int AFULL_TH   = F_DEPTH - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrt_en,
    input  logic [DT_WIDTH-1:0]   wrt_dt,
    input  logic                  rd_en,
    output logic [DT_WIDTH-1:0]   rd_dt,
    output logic                  rd_vld,
    output logic                  f_empty,
    output logic                  f_full,
    output logic                  f_aempty,
    output logic                  f_afull,
    output logic [FADD_WIDTH:0]   f_cnt,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  clr_err
);

    localparam int PW = FADD_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_V  = PW'(F_DEPTH);
    localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);
    localparam logic [PW-1:0] PTR_ONE  = {{FADD_WIDTH{1'b0}}, 1'b1};

    logic [PW-1:0]       wrt_pntr_q, wrt_pntr_d;
    logic [PW-1:0]       rd_pntr_q, rd_pntr_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [PW-1:0]       cnt;
    logic                wr_acc, rd_acc;
    logic [DT_WIDTH-1:0] mem_q [F_DEPTH];

    // Handshake: a write is taken when wrt_en is high and the FIFO is not full; a pop is taken when
    // rd_en is high and the FIFO is not empty. Both use the flags as they stand this cycle, so a
    // write into a full FIFO is dropped even if a pop happens alongside it.
    always_comb begin
        cnt      = wrt_pntr_q - rd_pntr_q;
        f_full   = (cnt == DEPTH_V);
        f_empty  = (cnt == '0);
        f_afull  = (cnt >= AFULL_V);
        f_aempty = (cnt <= AEMPTY_V);
        wr_acc   = wrt_en & ~f_full;
        rd_acc   = rd_en & ~f_empty;
    end

    always_comb begin
        wrt_pntr_d = wrt_pntr_q;
        rd_pntr_d  = rd_pntr_q;
        if (wr_acc) wrt_pntr_d = wrt_pntr_q + PTR_ONE;
        if (rd_acc) rd_pntr_d = rd_pntr_q + PTR_ONE;
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wrt_en & f_full) ovf_d = 1'b1;
        if (rd_en & f_empty) udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrt_pntr_q <= '0;
            rd_pntr_q  <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wrt_pntr_q <= wrt_pntr_d;
            rd_pntr_q  <= rd_pntr_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wrt_pntr_q[FADD_WIDTH-1:0]] <= wrt_dt;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DT_WIDTH-1:0] rd_dt_q, rd_dt_d;
            logic                rd_vld_q, rd_vld_d;

            always_comb begin
                rd_dt_d  = rd_dt_q;
                rd_vld_d = rd_acc;
                if (rd_acc) rd_dt_d = mem_q[rd_pntr_q[FADD_WIDTH-1:0]];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_dt_q  <= '0;
                    rd_vld_q <= 1'b0;
                end else begin
                    rd_dt_q  <= rd_dt_d;
                    rd_vld_q <= rd_vld_d;
                end
            end

            assign rd_dt  = rd_dt_q;
            assign rd_vld = rd_vld_q;
        end else begin : g_fwft_read
            // Head word is shown directly; a fresh write only becomes visible once the pointer moves.
            assign rd_dt  = mem_q[rd_pntr_q[FADD_WIDTH-1:0]];
            assign rd_vld = ~f_empty;
        end
    endgenerate

    assign f_cnt = cnt;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule
